// File: rtl/loader_pkg.sv
// Shared definitions for the UART boot loader.
//   state_t  : loader FSM states (also visible on uart_loader.state_dbg)
//   ACK_BYTE : byte sent to the host once the instruction section is stored
//   NAK_BYTE : byte sent to the host once the loader has entered ERR
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_LEN   = 3'd1,
    I_WORDS = 3'd2,
    ACK     = 3'd3,
    D_LEN   = 3'd4,
    D_WORDS = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'h55;

endpackage

// File: rtl/word_assembler.sv
// Packs a stream of bytes into 32-bit big-endian words.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : drops any partial word and restarts at byte position 0
//   byte_valid  : byte_in is taken on this cycle
//   byte_in     : incoming byte
//   word_valid  : combinational, high on the cycle the 4th byte is offered
//   word        : assembled word; first byte in bits 31:24, the 4th (current) byte in 7:0
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  pos_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      pos_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_in};
      pos_q   <= pos_q + 2'd1;  // wraps 3 -> 0 after each full word
    end
  end

  // The 4th byte is not stored: the word is presented while it is on the bus,
  // so the owner can register the write for the following cycle.
  assign word_valid = byte_valid && (pos_q == 2'd3);
  assign word       = {shift_q, byte_in};

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: receives an instruction section and a data section from a
// host, writes them into instruction/data memory, acknowledges and releases the CPU.
// Section format: 32-bit length word, then that many 32-bit words (big-endian).
// Optional feature macro LOADER_CHECKSUM_EN: each section is followed by one
// byte, the XOR of every byte of that section (length bytes included).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   rx_data, rx_ready      : received byte and its one-cycle strobe
//   tx_busy                : transmitter busy
//   tx_data, tx_start      : byte to send and its one-cycle strobe
//   rts                    : high while host bytes are accepted
//   imem_we/addr/wdata     : instruction memory write port (word address)
//   dmem_we/addr/wdata     : data memory write port (word address)
//   core_start             : one-cycle CPU release pulse
//   err                    : sticky error flag
//   state_dbg              : current FSM state (loader_pkg::state_t encoding)
// Handshakes: rx_ready is a strobe with no back-pressure; a byte is consumed only
// while rts is high and dropped otherwise. tx_start is issued only on a cycle
// where tx_busy was low, and is high for exactly one cycle per byte.
module uart_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 16384,
  parameter int DMEM_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        rts,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        core_start,
  output logic        err,
  output logic [2:0]  state_dbg
);

  state_t      state, state_next;
  logic [31:0] len_q, wcnt;
  logic        nak_sent;
  logic        in_len, in_words, in_i_sec;
  logic        asm_en, word_valid, sect_done;
  logic [31:0] word, depth;
  state_t      sect_next;

  assign in_len    = (state == I_LEN) || (state == D_LEN);
  assign in_words  = (state == I_WORDS) || (state == D_WORDS);
  assign in_i_sec  = (state == I_LEN) || (state == I_WORDS);
  assign depth     = (state == I_LEN) ? 32'(IMEM_DEPTH) : 32'(DMEM_DEPTH);
  assign sect_next = in_i_sec ? ACK : DONE;
  assign state_dbg = state;

`ifdef LOADER_CHECKSUM_EN
  // Once a section's words are in, the next byte is its checksum and must not
  // reach the assembler.
  logic       sum_wait;
  logic [7:0] sum_q;
  assign asm_en = rx_ready && (in_len || in_words) && !sum_wait;
`else
  assign asm_en = rx_ready && (in_len || in_words);
`endif

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_next != state),
    .byte_valid (asm_en),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sect_done  = 1'b0;
    case (state)
      IDLE: state_next = I_LEN;
      I_LEN, D_LEN: begin
        if (word_valid) begin
          if (word > depth)       state_next = ERR;
          else if (word == '0)    sect_done  = 1'b1;
          else if (state == I_LEN) state_next = I_WORDS;
          else                    state_next = D_WORDS;
        end
      end
      I_WORDS, D_WORDS: begin
        if (word_valid && (wcnt == len_q - 32'd1)) sect_done = 1'b1;
      end
      ACK: begin
        if (!tx_busy) state_next = D_LEN;
      end
      default: state_next = state;  // DONE and ERR hold until reset
    endcase
`ifdef LOADER_CHECKSUM_EN
    if (sum_wait && rx_ready) state_next = (rx_data == sum_q) ? sect_next : ERR;
`else
    if (sect_done) state_next = sect_next;
`endif
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q    <= '0;
      sum_wait <= 1'b0;
    end else begin
      // The running XOR spans LEN and WORDS, so it restarts only when a section begins.
      if ((state_next != state) && ((state_next == I_LEN) || (state_next == D_LEN)))
        sum_q <= '0;
      else if (asm_en)
        sum_q <= sum_q ^ rx_data;
      if (state_next != state) sum_wait <= 1'b0;
      else if (sect_done)      sum_wait <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      wcnt       <= '0;
      nak_sent   <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      rts        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      core_start <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      dmem_we  <= 1'b0;
      tx_start <= 1'b0;

      if (word_valid && (state == I_WORDS)) begin
        imem_we    <= 1'b1;
        imem_addr  <= wcnt;
        imem_wdata <= word;
      end
      if (word_valid && (state == D_WORDS)) begin
        dmem_we    <= 1'b1;
        dmem_addr  <= wcnt;
        dmem_wdata <= word;
      end

      if (word_valid && in_len) len_q <= word;

      // Word index restarts with every state; it saturates rather than wraps.
      if (state_next != state)
        wcnt <= '0;
      else if (word_valid && in_words && (wcnt != '1))
        wcnt <= wcnt + 32'd1;

      if ((state == ACK) && (state_next == D_LEN)) begin
        tx_start <= 1'b1;
        tx_data  <= ACK_BYTE;
      end
      if ((state == ERR) && !nak_sent && !tx_busy) begin
        tx_start <= 1'b1;
        tx_data  <= NAK_BYTE;
        nak_sent <= 1'b1;
      end

      // Status outputs follow the state being entered so they line up with it.
      rts        <= (state_next == I_LEN) || (state_next == I_WORDS) ||
                    (state_next == D_LEN) || (state_next == D_WORDS);
      err        <= (state_next == ERR);
      core_start <= (state_next == DONE) && (state != DONE);
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader. A host-side driver streams sections as
// bytes; a reference model derives every expected memory write, tx byte,
// core_start count and err level from the load description, and a monitor on
// the falling edge pops and compares as the DUT produces them.
module tb_uart_loader;

  localparam int IMEM_DEPTH = 16;
  localparam int DMEM_DEPTH = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_ready = 1'b0;
  logic        force_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start, rts, imem_we, dmem_we, core_start, err;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic [2:0]  state_dbg;

  assign tx_busy = force_busy | model_busy;

  uart_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .rts        (rts),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .core_start (core_start),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Transmitter model: busy for a random stretch after every tx_start.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        model_busy = 1'b1;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_imem_q[$];
  logic [63:0] exp_dmem_q[$];
  logic [7:0]  exp_tx_q[$];
  int          core_cnt = 0;
  int          exp_core = 0;
  logic        exp_err = 1'b0;
  logic [31:0] iw[$];
  logic [31:0] dw[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h, required no event", name, act);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (imem_we) begin
        if (exp_imem_q.size() == 0) unexpected("imem_write", {imem_addr, imem_wdata});
        else check("imem_write", {imem_addr, imem_wdata}, exp_imem_q.pop_front());
      end
      if (dmem_we) begin
        if (exp_dmem_q.size() == 0) unexpected("dmem_write", {dmem_addr, dmem_wdata});
        else check("dmem_write", {dmem_addr, dmem_wdata}, exp_dmem_q.pop_front());
      end
      if (tx_start) begin
        if (exp_tx_q.size() == 0) unexpected("tx_byte", 64'(tx_data));
        else check("tx_byte", 64'(tx_data), 64'(exp_tx_q.pop_front()));
      end
      if (core_start) core_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    rx_ready   = 1'b0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_rts", 64'(rts), 64'd0);
    check("rst_imem", {31'd0, imem_we, imem_addr}, 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_dmem", {31'd0, dmem_we, dmem_addr}, 64'd0);
    check("rst_dmem_wdata", 64'(dmem_wdata), 64'd0);
    check("rst_core_err", {core_start, err}, 64'd0);
    check("rst_state_idle", 64'(state_dbg), 64'd0);
    core_cnt = 0;
    reset = 1'b0;
    @(negedge clk);
    check("rts_after_reset", 64'(rts), 64'd1);
  endtask

  task automatic wait_rts();
    int t = 0;
    while (!rts && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("rts_wait", 64'(rts), 64'd1);
  endtask

  // Sends LEN, the section words from iw/dw and, when enabled, the checksum.
  // With junk set, tx_busy is held over the last byte so the loader parks in
  // ACK, and two stray bytes are sent there before releasing it.
  task automatic send_section(input logic [31:0] len, input bit is_d, input int gapmax,
                              input bit bad_cks, input bit junk);
    logic [7:0]  b[$];
    logic [7:0]  cks;
    logic [31:0] w;
    int          nw;
    for (int k = 3; k >= 0; k--) b.push_back(8'(len >> (8 * k)));
    nw = is_d ? dw.size() : iw.size();
    for (int i = 0; i < nw; i++) begin
      w = is_d ? dw[i] : iw[i];
      for (int k = 3; k >= 0; k--) b.push_back(8'(w >> (8 * k)));
    end
    cks = bad_cks ? 8'h5A : 8'h00;
    foreach (b[i]) cks = cks ^ b[i];
    if (CKS_EN) b.push_back(cks);
    for (int i = 0; i < b.size(); i++) begin
      if (junk && (i == b.size() - 1)) force_busy = 1'b1;
      send_byte(b[i], $urandom_range(0, gapmax));
    end
    if (junk) begin
      send_byte(8'($urandom), 0);
      send_byte(8'($urandom), 2);
      force_busy = 1'b0;
    end
  endtask

  // Reference model + stimulus for one complete load attempt.
  task automatic run_load(input int n, input int m, input int gapmax,
                          input bit bad_cks, input bit junk);
    bit i_fail;
    i_fail   = (n > IMEM_DEPTH) || bad_cks;
    exp_core = 0;
    exp_err  = 1'b0;
    if (n <= IMEM_DEPTH)
      for (int i = 0; i < n; i++) exp_imem_q.push_back({32'(i), iw[i]});
    if (i_fail) begin
      exp_tx_q.push_back(8'h55);
      exp_err = 1'b1;
    end else begin
      exp_tx_q.push_back(8'hAA);
      if (m > DMEM_DEPTH) begin
        exp_tx_q.push_back(8'h55);
        exp_err = 1'b1;
      end else begin
        for (int i = 0; i < m; i++) exp_dmem_q.push_back({32'(i), dw[i]});
        exp_core = 1;
      end
    end

    send_section(32'(n), 1'b0, gapmax, bad_cks, junk && !i_fail);
    if (!i_fail) begin
      wait_rts();
      send_section(32'(m), 1'b1, gapmax, 1'b0, 1'b0);
    end
    repeat (60) @(negedge clk);
    // Bytes arriving after DONE/ERR must be ignored.
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 20);

    check("err_flag", 64'(err), 64'(exp_err));
    check("rts_final", 64'(rts), 64'd0);
    check("core_start_count", 64'(core_cnt), 64'(exp_core));
    check("imem_pending", 64'(exp_imem_q.size()), 64'd0);
    check("dmem_pending", 64'(exp_dmem_q.size()), 64'd0);
    check("tx_pending", 64'(exp_tx_q.size()), 64'd0);
    exp_imem_q.delete();
    exp_dmem_q.delete();
    exp_tx_q.delete();
  endtask

  task automatic fill_rand(input int n, input int m);
    iw.delete();
    dw.delete();
    for (int i = 0; i < n; i++) iw.push_back($urandom);
    for (int i = 0; i < m; i++) dw.push_back($urandom);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Two instruction words, empty data section.
    do_reset();
    iw = '{32'h12345678, 32'hDEADBEEF};
    dw.delete();
    run_load(2, 0, 3, 1'b0, 1'b0);

    // Both sections empty.
    do_reset();
    fill_rand(0, 0);
    run_load(0, 0, 2, 1'b0, 1'b0);

    // Instruction length one past capacity.
    do_reset();
    fill_rand(0, 0);
    run_load(IMEM_DEPTH + 1, 0, 2, 1'b0, 1'b0);

    // Data 1,2,3 with long irregular gaps; stray bytes while parked in ACK.
    do_reset();
    fill_rand(2, 0);
    dw = '{32'd1, 32'd2, 32'd3};
    run_load(2, 3, 50, 1'b0, 1'b1);

    // Reset after two bytes of the first instruction word.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 2);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_reset();
    fill_rand(2, 1);
    run_load(2, 1, 2, 1'b0, 1'b0);

    // Full-capacity sections, then data length one past capacity.
    do_reset();
    fill_rand(IMEM_DEPTH, DMEM_DEPTH);
    run_load(IMEM_DEPTH, DMEM_DEPTH, 1, 1'b0, 1'b0);
    do_reset();
    fill_rand(1, 0);
    run_load(1, DMEM_DEPTH + 1, 1, 1'b0, 1'b0);

    // Random loads.
    for (int r = 0; r < 5; r++) begin
      int n, m;
      n = $urandom_range(0, IMEM_DEPTH);
      m = $urandom_range(0, DMEM_DEPTH);
      do_reset();
      fill_rand(n, m);
      run_load(n, m, $urandom_range(0, 4), 1'b0, ($urandom_range(0, 1) == 1));
    end

`ifdef LOADER_CHECKSUM_EN
    // One instruction word with a corrupted checksum byte.
    do_reset();
    iw = '{32'h000000FF};
    dw.delete();
    run_load(1, 0, 1, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
